// File: rtl/fastram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fastram_pkg
// Description : Shared types for the fast-RAM to SDRAM bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package fastram_pkg;

    localparam int FASTRAM_ADDR_W = 23;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_REQ  = 2'd1,
        RD_REQ  = 2'd2,
        RD_DONE = 2'd3
    } fsm_state_t;

    typedef struct packed {
        logic [FASTRAM_ADDR_W-1:0] addr;
        logic [7:0]                data;
    } wr_entry_t;

endpackage
`default_nettype wire

// File: rtl/fastram_wfifo.sv
`default_nettype none
// ============================================================================
// Module      : fastram_wfifo
// Description : Synchronous FIFO with head output; extra pointer MSB
//               separates full from empty.
// Revision    : 1.0 - initial release
// ============================================================================
module fastram_wfifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 31
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (c_AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (c_AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_din;
    end

endmodule
`default_nettype wire

// File: rtl/fastram_bridge.sv
`default_nettype none
// ============================================================================
// Module      : fastram_bridge
// Description : Posts CPU fast-RAM writes into a FIFO, serialises reads
//               behind them and drives a level req/ack SDRAM handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module fastram_bridge
    import fastram_pkg::*;
#(
    parameter int WBUF_DEPTH = 4,
    parameter int ADDR_W     = 23,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              fast_clk,
    input  logic              fastram_ce,
    input  logic              fastram_we,
    input  logic [ADDR_W-1:0] fastram_address,
    input  logic [7:0]        fastram_datatoram,
    output logic [7:0]        fastram_datafromram,
    output logic              cpu_wait,
    output logic              sdram_req,
    output logic              sdram_we,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [7:0]        sdram_din,
    input  logic [7:0]        sdram_dout,
    input  logic              sdram_ack,
    output logic              timeout_err
);

    localparam int               c_TO_W   = $clog2(TIMEOUT + 1);
    localparam logic [c_TO_W-1:0] c_TO_MAX = c_TO_W'(TIMEOUT);

    fsm_state_t        r_state, w_state_nxt;
    logic              r_cpu_wait;
    logic              r_skid_vld;
    wr_entry_t         r_skid;
    logic              r_rd_pend;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [7:0]        r_rdata;
    logic [c_TO_W-1:0] r_to_cnt, w_to_nxt;
    logic              r_timeout_err;

    logic              w_sample, w_wr_sample, w_rd_sample;
    logic              w_full, w_empty, w_push, w_skid_push, w_pop;
    wr_entry_t         w_new_entry, w_push_data, w_head;
    logic              w_req, w_we, w_rd_cap, w_rd_done;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_din;

    // Strobes are ignored while stalled; the core holds its access meanwhile
    assign w_sample    = fast_clk && fastram_ce && !r_cpu_wait;
    assign w_wr_sample = w_sample && fastram_we;
    assign w_rd_sample = w_sample && !fastram_we;
    assign w_new_entry = '{addr: FASTRAM_ADDR_W'(fastram_address), data: fastram_datatoram};
    assign w_skid_push = r_skid_vld && !w_full;
    assign w_push      = w_skid_push || (w_wr_sample && !w_full);
    assign w_push_data = r_skid_vld ? r_skid : w_new_entry;

    fastram_wfifo #(
        .DEPTH (WBUF_DEPTH),
        .WIDTH ($bits(wr_entry_t))
    ) u_wfifo (
        .clk     (clk_sys),
        .rst_n   (reset_n),
        .i_push  (w_push),
        .i_din   (w_push_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_we        = 1'b0;
        w_addr      = '0;
        w_din       = '0;
        w_pop       = 1'b0;
        w_rd_cap    = 1'b0;
        w_rd_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty)       w_state_nxt = WR_REQ;
                else if (r_rd_pend) w_state_nxt = RD_REQ;
            end
            WR_REQ: begin
                w_req  = 1'b1;
                w_we   = 1'b1;
                w_addr = ADDR_W'(w_head.addr);
                w_din  = w_head.data;
                if (sdram_ack) begin
                    w_pop       = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            RD_REQ: begin
                w_req  = 1'b1;
                w_addr = r_rd_addr;
                if (sdram_ack) begin
                    w_rd_cap    = 1'b1;
                    w_state_nxt = RD_DONE;
                end
            end
            RD_DONE: begin
                w_rd_done   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Saturating request-age counter; the request itself is never aborted
    always_comb begin
        w_to_nxt = '0;
        if (w_req && !sdram_ack)
            w_to_nxt = (r_to_cnt == c_TO_MAX) ? r_to_cnt : r_to_cnt + c_TO_W'(1);
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_cpu_wait    <= 1'b0;
            r_skid_vld    <= 1'b0;
            r_skid        <= '0;
            r_rd_pend     <= 1'b0;
            r_rd_addr     <= '0;
            r_rdata       <= 8'h00;
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_to_cnt <= w_to_nxt;
            if (w_to_nxt == c_TO_MAX) r_timeout_err <= 1'b1;
            if (w_wr_sample && w_full) begin
                r_skid     <= w_new_entry;
                r_skid_vld <= 1'b1;
                r_cpu_wait <= 1'b1;
            end else if (w_skid_push) begin
                r_skid_vld <= 1'b0;
                r_cpu_wait <= 1'b0;
            end
            if (w_rd_sample) begin
                r_rd_addr  <= fastram_address;
                r_rd_pend  <= 1'b1;
                r_cpu_wait <= 1'b1;
            end
            if (w_rd_cap) r_rdata <= sdram_dout;
            if (w_rd_done) begin
                r_rd_pend  <= 1'b0;
                r_cpu_wait <= 1'b0;
            end
        end
    end

    assign fastram_datafromram = r_rdata;
    assign cpu_wait            = r_cpu_wait;
    assign sdram_req           = w_req;
    assign sdram_we            = w_we;
    assign sdram_addr          = w_addr;
    assign sdram_din           = w_din;
    assign timeout_err         = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_fastram_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_fastram_bridge
// Description : Directed self-checking bench for fastram_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fastram_bridge;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        fast_clk = 1'b0;
    logic        fastram_ce = 1'b0;
    logic        fastram_we = 1'b0;
    logic [22:0] fastram_address = '0;
    logic [7:0]  fastram_datatoram = '0;
    logic [7:0]  fastram_datafromram;
    logic        cpu_wait;
    logic        sdram_req;
    logic        sdram_we;
    logic [22:0] sdram_addr;
    logic [7:0]  sdram_din;
    logic [7:0]  sdram_dout = '0;
    logic        sdram_ack = 1'b0;
    logic        timeout_err;

    int n_cmp = 0;
    int n_err = 0;
    int wait_cnt = 0;
    logic [7:0] model [logic [22:0]];

    fastram_bridge #(.WBUF_DEPTH(4), .ADDR_W(23), .TIMEOUT(255)) dut (
        .clk_sys             (clk_sys),
        .reset_n             (reset_n),
        .fast_clk            (fast_clk),
        .fastram_ce          (fastram_ce),
        .fastram_we          (fastram_we),
        .fastram_address     (fastram_address),
        .fastram_datatoram   (fastram_datatoram),
        .fastram_datafromram (fastram_datafromram),
        .cpu_wait            (cpu_wait),
        .sdram_req           (sdram_req),
        .sdram_we            (sdram_we),
        .sdram_addr          (sdram_addr),
        .sdram_din           (sdram_din),
        .sdram_dout          (sdram_dout),
        .sdram_ack           (sdram_ack),
        .timeout_err         (timeout_err)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) if (cpu_wait) wait_cnt <= wait_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_sys);
    endtask

    // One fast_clk phase strobe; returns at the negedge after the sampling edge
    task automatic cpu_strobe(input logic we, input logic [22:0] addr, input logic [7:0] data);
        fast_clk = 1'b1; fastram_ce = 1'b1; fastram_we = we;
        fastram_address = addr; fastram_datatoram = data;
        tick();
        fast_clk = 1'b0; fastram_ce = 1'b0; fastram_we = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Wait for a request, hold off `delay` cycles, then ack it from the model
    task automatic serve(input int delay, output logic s_we, output logic [22:0] s_addr,
                         output logic [7:0] s_din);
        int n;
        n = 0;
        while (!sdram_req && n < 20) begin tick(); n++; end
        check("req_arrives", 32'(sdram_req), 1);
        idle(delay);
        s_we = sdram_we; s_addr = sdram_addr; s_din = sdram_din;
        if (s_we) model[s_addr] = s_din;
        sdram_dout = (!s_we && model.exists(s_addr)) ? model[s_addr] : 8'hEE;
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0; sdram_dout = 8'h00;
        check("req_drop_after_ack", 32'(sdram_req), 0);
    endtask

    logic        s_we;
    logic [22:0] s_addr;
    logic [7:0]  s_din;
    logic [22:0] t3_addr [5] = '{23'h000100, 23'h020200, 23'h040300, 23'h7F0401, 23'h000505};
    logic [7:0]  t3_data [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    int          snap;
    int          cnt;

    initial begin
        // Reset state
        idle(3);
        check("rst_req", 32'(sdram_req), 0);
        check("rst_we", 32'(sdram_we), 0);
        check("rst_addr", 32'(sdram_addr), 0);
        check("rst_din", 32'(sdram_din), 0);
        check("rst_wait", 32'(cpu_wait), 0);
        check("rst_rdata", 32'(fastram_datafromram), 0);
        check("rst_terr", 32'(timeout_err), 0);
        reset_n = 1'b1;
        idle(2);

        // Single posted write
        snap = wait_cnt;
        cpu_strobe(1'b1, 23'h012345, 8'hA5);
        serve(3, s_we, s_addr, s_din);
        check("t1_we", 32'(s_we), 1);
        check("t1_addr", 32'(s_addr), 32'h012345);
        check("t1_din", 32'(s_din), 32'hA5);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin tick(); if (sdram_req) cnt++; end
        check("t1_fifo_empty", 32'(cnt), 0);
        check("t1_no_wait", 32'(wait_cnt - snap), 0);

        // Single read
        model[23'h000400] = 8'h5C;
        cpu_strobe(1'b0, 23'h000400, 8'h00);
        check("t2_wait_rise", 32'(cpu_wait), 1);
        serve(5, s_we, s_addr, s_din);
        check("t2_we", 32'(s_we), 0);
        check("t2_addr", 32'(s_addr), 32'h000400);
        check("t2_rdata", 32'(fastram_datafromram), 32'h5C);
        check("t2_wait_ack1", 32'(cpu_wait), 1);
        tick();
        check("t2_wait_ack2", 32'(cpu_wait), 0);
        idle(4);
        check("t2_rdata_hold", 32'(fastram_datafromram), 32'h5C);

        // Five writes into a depth-4 FIFO with acks withheld
        for (int i = 0; i < 5; i++) begin
            cpu_strobe(1'b1, t3_addr[i], t3_data[i]);
            check("t3_wait_on_push", 32'(cpu_wait), (i == 4) ? 1 : 0);
            idle(7);
        end
        check("t3_wait_held", 32'(cpu_wait), 1);
        for (int i = 0; i < 5; i++) begin
            serve(1, s_we, s_addr, s_din);
            check("t3_we", 32'(s_we), 1);
            check("t3_addr", 32'(s_addr), 32'(t3_addr[i]));
            check("t3_din", 32'(s_din), 32'(t3_data[i]));
            if (i == 0) check("t3_wait_before_skid_push", 32'(cpu_wait), 1);
            if (i == 1) check("t3_wait_released", 32'(cpu_wait), 0);
        end

        // Write then read of the same address: strict W,R order
        cpu_strobe(1'b1, 23'h7F0010, 8'h11);
        idle(7);
        cpu_strobe(1'b0, 23'h7F0010, 8'h00);
        check("t4_wait_rise", 32'(cpu_wait), 1);
        serve(2, s_we, s_addr, s_din);
        check("t4_first_is_write", 32'(s_we), 1);
        check("t4_wr_addr", 32'(s_addr), 32'h7F0010);
        check("t4_wr_din", 32'(s_din), 32'h11);
        serve(2, s_we, s_addr, s_din);
        check("t4_second_is_read", 32'(s_we), 0);
        check("t4_rd_addr", 32'(s_addr), 32'h7F0010);
        check("t4_rdata", 32'(fastram_datafromram), 32'h11);
        tick();
        check("t4_wait_fall", 32'(cpu_wait), 0);

        // Timeout: ack withheld for 300 request cycles
        cpu_strobe(1'b1, 23'h003000, 8'h77);
        cnt = 0;
        while (!sdram_req && cnt < 20) begin tick(); cnt++; end
        check("t5_req", 32'(sdram_req), 1);
        cnt = 0;
        for (int n = 2; n <= 300; n++) begin
            tick();
            if (!sdram_req) cnt++;
            if (n == 255) check("t5_terr_before", 32'(timeout_err), 0);
            if (n == 256) check("t5_terr_set", 32'(timeout_err), 1);
        end
        check("t5_req_held", 32'(cnt), 0);
        check("t5_addr_stable", 32'(sdram_addr), 32'h003000);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        idle(3);
        check("t5_terr_sticky", 32'(timeout_err), 1);
        check("t5_req_done", 32'(sdram_req), 0);

        // Reset mid-transaction with writes and a read queued
        cpu_strobe(1'b1, 23'h000A00, 8'hAA);
        idle(7);
        cpu_strobe(1'b1, 23'h000B00, 8'hBB);
        idle(7);
        cpu_strobe(1'b0, 23'h000C00, 8'h00);
        idle(3);
        check("t6_req_pre", 32'(sdram_req), 1);
        reset_n = 1'b0;
        tick();
        check("t6_req", 32'(sdram_req), 0);
        check("t6_wait", 32'(cpu_wait), 0);
        check("t6_terr", 32'(timeout_err), 0);
        check("t6_rdata", 32'(fastram_datafromram), 0);
        check("t6_addr", 32'(sdram_addr), 0);
        check("t6_we", 32'(sdram_we), 0);
        tick();
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin tick(); if (sdram_req || cpu_wait) cnt++; end
        check("t6_quiet_after_reset", 32'(cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire
